// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared op encodings, FSM state enum and default widths for dm_lsu
package dm_pkg;

    localparam int DM_AW = 12;
    localparam int DM_DW = 16;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        FILL    = 3'd3,
        CP_RD   = 3'd4,
        CP_WAIT = 3'd5,
        CP_WR   = 3'd6,
        RESP    = 3'd7
    } dm_state_e;

endpackage

// File: rtl/dm_burst_ctr.sv
// rtl/dm_burst_ctr.sv - remaining-word counter with source/destination address incrementers
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture len/src/dst for a new burst
//   step         : one word done; decrement count, advance both addresses
//   len_i        : burst word count
//   src_i, dst_i : start addresses
//   last_o       : current word is the final one
//   src_inc_o    : next source address (wraps modulo 2^AW)
//   dst_o        : current destination address
module dm_burst_ctr #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [7:0]    len_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    output logic          last_o,
    output logic [AW-1:0] src_inc_o,
    output logic [AW-1:0] dst_o
);

    logic [7:0]    rem_q, rem_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;

    always_comb begin
        rem_d = rem_q;
        src_d = src_q;
        dst_d = dst_q;
        if (load) begin
            rem_d = len_i;
            src_d = src_i;
            dst_d = dst_i;
        end else if (step) begin
            rem_d = rem_q - 8'd1;
            src_d = src_q + AW'(1);
            dst_d = dst_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            src_q <= '0;
            dst_q <= '0;
        end else begin
            rem_q <= rem_d;
            src_q <= src_d;
            dst_q <= dst_d;
        end
    end

    assign last_o    = (rem_q == 8'd1);
    assign src_inc_o = src_q + AW'(1);
    assign dst_o     = dst_q;

endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store/fill/copy initiator for the datamem 4Kx16 memory
//   config macro  : DM_LSU_BURST_EN builds fill/copy; otherwise ops 10/11 return rsp_err
//   request side  : req_valid/req_ready, req_op, req_addr, req_dst, req_wdata, req_len
//   response side : rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   memory side   : we_DM, addDM, dataDM (registered), outDM
//   status        : busy
module dm_lsu
    import dm_pkg::*;
#(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_dst,
    input  logic [DW-1:0] req_wdata,
    input  logic [7:0]    req_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          we_DM,
    output logic [AW-1:0] addDM,
    output logic [DW-1:0] dataDM,
    input  logic [DW-1:0] outDM,
    output logic          busy
);

    localparam logic [1:0] RL = 2'(READ_LAT);

    dm_state_e     state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] add_q, add_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    wcnt_q, wcnt_d;

`ifdef DM_LSU_BURST_EN
    logic          ctr_load, ctr_step, ctr_last;
    logic [AW-1:0] ctr_src_inc, ctr_dst;

    dm_burst_ctr #(.AW(AW)) u_burst_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .step      (ctr_step),
        .len_i     (req_len),
        .src_i     (req_addr),
        .dst_i     (req_dst),
        .last_o    (ctr_last),
        .src_inc_o (ctr_src_inc),
        .dst_o     (ctr_dst)
    );
`else
    logic unused_burst_inputs;
    assign unused_burst_inputs = ^{req_len, req_dst};
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        add_d   = add_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
`ifdef DM_LSU_BURST_EN
        ctr_load = 1'b0;
        ctr_step = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    if (req_op == OP_LOAD) begin
                        add_d   = req_addr;
                        state_d = RD_WAIT;
                    end else if (req_op == OP_STORE) begin
                        add_d   = req_addr;
                        data_d  = req_wdata;
                        we_d    = 1'b1;
                        state_d = WR;
                    end else begin
`ifdef DM_LSU_BURST_EN
                        if (req_len == 8'd0) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end else begin
                            ctr_load = 1'b1;
                            add_d    = req_addr;
                            if (req_op == OP_FILL) begin
                                data_d  = req_wdata;
                                we_d    = 1'b1;
                                state_d = FILL;
                            end else begin
                                state_d = CP_RD;
                            end
                        end
`else
                        err_d   = 1'b1;
                        state_d = RESP;
`endif
                    end
                end
            end
            // addDM was driven on entry; outDM is valid READ_LAT cycles later
            RD_WAIT: begin
                if (wcnt_q == RL) begin
                    rdata_d = outDM;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            WR: state_d = RESP;
`ifdef DM_LSU_BURST_EN
            FILL: begin
                if (ctr_last) begin
                    state_d = RESP;
                end else begin
                    ctr_step = 1'b1;
                    add_d    = ctr_src_inc;
                    we_d     = 1'b1;
                end
            end
            CP_RD: begin
                wcnt_d  = 2'd1;
                state_d = CP_WAIT;
            end
            CP_WAIT: begin
                if (wcnt_q == RL) begin
                    data_d  = outDM;
                    add_d   = ctr_dst;
                    we_d    = 1'b1;
                    state_d = CP_WR;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            CP_WR: begin
                if (ctr_last) begin
                    state_d = RESP;
                end else begin
                    ctr_step = 1'b1;
                    add_d    = ctr_src_inc;
                    state_d  = CP_RD;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            add_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            add_q   <= add_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign we_DM     = we_q;
    assign addDM     = add_q;
    assign dataDM    = data_q;

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - scoreboard testbench for dm_lsu with a READ_LAT=1 memory model
module tb_dm_lsu;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_addr = '0;
    logic [11:0] req_dst = '0;
    logic [15:0] req_wdata = '0;
    logic [7:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        we_DM;
    logic [11:0] addDM;
    logic [15:0] dataDM;
    logic [15:0] outDM = '0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    logic mem_clr = 1'b1;

    logic [15:0] mem [4096];
    logic [15:0] ref_mem [4096];
    logic [16:0] sb [$];

`ifdef DM_LSU_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    dm_lsu #(.AW(12), .DW(16), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dst(req_dst), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .we_DM(we_DM), .addDM(addDM), .dataDM(dataDM), .outDM(outDM), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (we_DM) begin
            mem[addDM] <= dataDM;
        end
        outDM <= mem[addDM];
    end

    always @(negedge clk) if (we_DM) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [1:0] op, input logic [11:0] a,
                           input logic [11:0] d, input logic [15:0] w, input logic [7:0] n,
                           input int exp_lat, input int hold);
        logic [16:0] e;
        logic        e_err;
        logic [15:0] e_data;
        logic        stable;
        int          k, we0, exp_we, tmo;
        e_err  = (op[1] == 1'b1) && (!BURST || n == 8'd0);
        e_data = (op == OP_LOAD) ? ref_mem[a] : 16'h0;
        exp_we = (op == OP_STORE) ? 1 : (op[1] && !e_err) ? int'(n) : 0;
        sb.push_back({e_err, e_data});
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_dst = d; req_wdata = w; req_len = n;
        tmo = 0;
        while (!req_ready && tmo < 100) begin @(negedge clk); tmo++; end
        check({tag, " accept"}, req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        we0 = we_cnt;
        if (op == OP_STORE) ref_mem[a] = w;
        if (op[1] && !e_err) begin
            for (int i = 0; i < int'(n); i++) begin
                if (op == OP_FILL) ref_mem[a + 12'(i)] = w;
                else ref_mem[d + 12'(i)] = ref_mem[a + 12'(i)];
            end
        end
        @(negedge clk);
        k = 1;
        while (!rsp_valid && k < 2000) begin @(negedge clk); k++; end
        check({tag, " latency"}, k, exp_lat);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!rsp_valid || rsp_rdata !== e_data || req_ready) stable = 1'b0;
            req_valid = 1'b1; req_op = OP_STORE; req_addr = 12'h7FF; req_wdata = 16'hDEAD;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (hold > 0) check({tag, " hold_stable"}, stable, 1'b1);
        rsp_ready = 1'b1;
        e = (sb.size() > 0) ? sb.pop_front() : 17'h1FFFF;
        check({tag, " rdata"}, rsp_rdata, e[15:0]);
        check({tag, " err"}, rsp_err, e[16]);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " we_pulses"}, we_cnt - we0, exp_we);
    endtask

    initial begin
        logic [11:0] ra;
        logic [15:0] rd;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        #2;
        check("reset we_DM", we_DM, 0);
        check("reset addDM", addDM, 0);
        check("reset dataDM", dataDM, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset busy", busy, 0);
        check("reset req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        rst_n = 1'b1;

        run_req("st0", OP_STORE, 12'h000, 12'h0, 16'h00FE, 8'd0, 2, 0);
        run_req("ld0", OP_LOAD, 12'h000, 12'h0, 16'h0, 8'd0, 3, 0);
        run_req("st10", OP_STORE, 12'h010, 12'h0, 16'h1111, 8'd0, 2, 0);
        run_req("st11", OP_STORE, 12'h011, 12'h0, 16'h2222, 8'd0, 2, 0);
        run_req("st12", OP_STORE, 12'h012, 12'h0, 16'h3333, 8'd0, 2, 0);
        run_req("ld11_bp", OP_LOAD, 12'h011, 12'h0, 16'h0, 8'd0, 3, 5);
        run_req("ld7ff", OP_LOAD, 12'h7FF, 12'h0, 16'h0, 8'd0, 3, 0);

        for (int i = 0; i < 4; i++) begin
            ra = 12'($urandom_range(12'h200, 12'h2FF));
            rd = 16'($urandom);
            run_req("rnd_st", OP_STORE, ra, 12'h0, rd, 8'd0, 2, 0);
            run_req("rnd_ld", OP_LOAD, ra, 12'h0, 16'h0, 8'd0, 3, 0);
        end

        if (BURST) begin
            run_req("fill_wrap", OP_FILL, 12'hFFE, 12'h0, 16'h00D1, 8'd4, 5, 0);
            run_req("ld_ffe", OP_LOAD, 12'hFFE, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_fff", OP_LOAD, 12'hFFF, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_000", OP_LOAD, 12'h000, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_001", OP_LOAD, 12'h001, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("copy3", OP_COPY, 12'h010, 12'h020, 16'h0, 8'd3, 10, 0);
            run_req("ld_020", OP_LOAD, 12'h020, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_021", OP_LOAD, 12'h021, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_022", OP_LOAD, 12'h022, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("fill_len0", OP_FILL, 12'h300, 12'h0, 16'h5555, 8'd0, 1, 0);
            run_req("copy_len0", OP_COPY, 12'h010, 12'h310, 16'h0, 8'd0, 1, 0);
        end else begin
            run_req("copy_off", OP_COPY, 12'h010, 12'h020, 16'h0, 8'd3, 1, 0);
            run_req("fill_off", OP_FILL, 12'h030, 12'h0, 16'hAAAA, 8'd4, 1, 0);
            run_req("ld_020", OP_LOAD, 12'h020, 12'h0, 16'h0, 8'd0, 3, 0);
            run_req("ld_030", OP_LOAD, 12'h030, 12'h0, 16'h0, 8'd0, 3, 0);
        end

        @(negedge clk);
        req_valid = 1'b1; req_addr = 12'h100; req_wdata = 16'hBEEF; req_len = 8'd8;
        req_op = BURST ? OP_FILL : OP_LOAD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (BURST) ref_mem[12'h100] = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst we_DM", we_DM, 0);
        check("midrst busy", busy, 0);
        check("midrst req_ready", req_ready, 1);
        check("midrst rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("ld_100", OP_LOAD, 12'h100, 12'h0, 16'h0, 8'd0, 3, 0);
        run_req("ld_101", OP_LOAD, 12'h101, 12'h0, 16'h0, 8'd0, 3, 0);
        run_req("ld_107", OP_LOAD, 12'h107, 12'h0, 16'h0, 8'd0, 3, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store initiator for the 4K×16 data memory (`datamem`). It drives the memory's `we_DM`/`addDM`/`dataDM` pins and captures `outDM` on behalf of the CPU execute stage. Requests arrive over a valid/ready handshake and results leave over a valid/ready handshake. With the burst feature compiled in, the block also executes multi-word fill and copy operations autonomously.

## Interface
Parameters:
- `AW`, 12, memory address width.
- `DW`, 16, memory data width.
- `READ_LAT`, 1, cycles from `addDM` driven to `outDM` valid; legal range 1..3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  operation: 00 load, 01 store, 10 fill, 11 copy.
- `req_addr`  in  AW  load/store address; fill destination; copy source.
- `req_dst`  in  AW  copy destination.
- `req_wdata`  in  DW  store/fill data.
- `req_len`  in  8  burst word count, 1..255.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DW  load data; 0 for all other ops.
- `rsp_err`  out  1  request rejected.
- `we_DM`  out  1  memory write enable.
- `addDM`  out  AW  memory address.
- `dataDM`  out  DW  memory write data.
- `outDM`  in  DW  memory read data.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, WR, FILL, CP_RD, CP_WAIT, CP_WR, RESP.
- `req_ready` = (state == IDLE). A request is accepted on a clock edge where `req_valid && req_ready`.
- All request fields are latched at acceptance. Changes to inputs afterward have no effect.
- **Load:** IDLE → RD_WAIT. The block drives `addDM`, waits READ_LAT cycles, latches `outDM` into `rsp_rdata`, then → RESP.
- **Store:** IDLE → WR. `we_DM`=1 for exactly one cycle with the latched `addDM`/`dataDM`, then → RESP.
- **Fill:** FILL writes `req_wdata` to addresses addr, addr+1, …, one word per cycle, for `req_len` words, then → RESP.
- **Copy:** the block loops CP_RD → CP_WAIT (READ_LAT cycles) → CP_WR.
  - Each iteration reads from src+i and writes the captured word to dst+i.
  - After `req_len` iterations → RESP.
- **RESP:** `rsp_valid`=1, held stable until `rsp_ready`. On the handshake edge → IDLE.
- **Address arithmetic:** modulo 2^AW. Address 0xFFF increments to 0x000 with no error.
- **`req_len` = 0** on fill/copy: no memory access; → RESP with `rsp_err`=1.
- **Overlapping copy ranges:** strictly ascending order; no overlap correction.
- **Reset:** asynchronous and takes effect immediately, including mid-burst. After reset:
  - state IDLE;
  - `we_DM`, `addDM`, `dataDM`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy` all 0;
  - `req_ready` 1.
  - A partial burst is abandoned; words already written stay written.
- `we_DM`, `addDM` and `dataDM` are registered. When not writing, `we_DM`=0 and `addDM`/`dataDM` hold their last values.

## Timing
Acceptance edge is T0.
- **Load:** `addDM` valid from T0+1. `rsp_valid` rises at T0+1+READ_LAT+1, giving T0+3 for READ_LAT=1.
- **Store:** `we_DM` high during cycle T0+1. `rsp_valid` at T0+2.
- **Fill of N words:** writes in cycles T0+1…T0+N. `rsp_valid` at T0+N+1.
- **Copy of N words:** each word takes READ_LAT+2 cycles. `rsp_valid` at T0+N·(READ_LAT+2)+1.
- Earliest next acceptance is the edge after the `rsp_valid && rsp_ready` handshake. `req_ready` is 0 throughout the operation.

## Configuration
- Macro: `DM_LSU_BURST_EN`.
- **Defined:** fill and copy behave as above.
- **Undefined:** FILL/CP_* states and the burst counter are not built.
  - Ops 10/11 are accepted, perform no memory access, and go directly to RESP with `rsp_err`=1, `rsp_rdata`=0.
  - `req_len` and `req_dst` are ignored.

## Structure
- Package `dm_pkg` holds:
  - op encodings (`OP_LOAD`, `OP_STORE`, `OP_FILL`, `OP_COPY`);
  - the FSM state enum;
  - default `AW`/`DW`.
- Sub-module `dm_burst_ctr`: 8-bit remaining-word counter plus source and destination address incrementers with modulo wrap. It is instantiated only under `DM_LSU_BURST_EN`.

## Test plan
- **Store then load:** store 0x00FE to addr 0x000, then load 0x000 → `we_DM` pulse of exactly 1 cycle; `rsp_rdata`=0x00FE, `rsp_err`=0; load `rsp_valid` at T0+3.
- **Fill with wrap:** fill addr 0xFFE, len 4, data 0x00D1 → writes to 0xFFE, 0xFFF, 0x000, 0x001; `rsp_valid` at T0+5; subsequent loads return 0x00D1.
- **Copy:** copy src 0x010, dst 0x020, len 3 after preloading 0x1111/0x2222/0x3333 → loads of 0x020..0x022 return the same values; `rsp_valid` at T0+10.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0, a new `req_valid` is not accepted.
- **Reset mid-fill:** assert `rst_n`=0 during word 2 of a len-8 fill → `we_DM`=0 immediately, `busy`=0, `req_ready`=1; only the first words are written.
- **Length zero / burst disabled:** fill with len 0 → `rsp_err`=1, no `we_DM` pulse. Without the macro, op 11 → `rsp_err`=1 at T0+1.
